// File: rtl/clk_reset_sequencer.sv
// PLL lock qualification and core reset sequencing, clocked from the 12 MHz reference.
// Optional watchdog is built in when CLK_RESET_SEQUENCER_WDT_EN is defined.
module clk_reset_sequencer #(
  parameter int unsigned LOCK_CYCLES    = 4,
  parameter int unsigned HOLD_CYCLES    = 128,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned WDT_CYCLES     = 1048576
) (
  input  logic       c,
  input  logic       r,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  input  logic       wdt_kick,
  output logic       pll_resetb,
  output logic       core_reset,
  output logic       running,
  output logic [1:0] reset_cause
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned PRST_W = $clog2(PLL_RST_CYCLES) + 1;

  localparam logic [1:0] CAUSE_POR       = 2'b00;
  localparam logic [1:0] CAUSE_LOCK_LOST = 2'b01;
  localparam logic [1:0] CAUSE_SOFT      = 2'b10;
  localparam logic [1:0] CAUSE_WDT       = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_PLL_RST   = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                lock_meta_q, lock_s_q;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [PRST_W-1:0]   prst_cnt_q, prst_cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic                pll_resetb_q, pll_resetb_d;
  logic                core_reset_q, core_reset_d;
  logic                running_q, running_d;
  logic                wdt_exp_c;

`ifdef CLK_RESET_SEQUENCER_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES) + 1;

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  // Counter is held at zero outside RUN, so it starts from zero on every RUN entry.
  always_comb begin
    wdt_cnt_d = '0;
    if (state_q == S_RUN && !wdt_kick) begin
      wdt_cnt_d = (wdt_cnt_q == '1) ? wdt_cnt_q : wdt_cnt_q + WDT_W'(1);
    end
    wdt_exp_c = (state_q == S_RUN) && !wdt_kick &&
                (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
  end

  always_ff @(posedge c) begin
    if (r) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic unused_c;

  assign wdt_exp_c = 1'b0;
  assign unused_c  = wdt_kick ^ WDT_CYCLES[0];
`endif

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    prst_cnt_d = prst_cnt_q;
    cause_d    = cause_q;

    case (state_q)
      S_WAIT_LOCK: begin
        lock_cnt_d = !lock_s_q ? '0 :
                     (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
        to_cnt_d   = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
        // Lock qualification takes precedence over a coincident timeout.
        if (lock_cnt_d >= LOCK_W'(LOCK_CYCLES)) begin
          state_d = S_HOLD;
        end else if (to_cnt_d >= TO_W'(LOCK_TIMEOUT)) begin
          state_d = S_PLL_RST;
        end
      end
      S_PLL_RST: begin
        prst_cnt_d = (prst_cnt_q == '1) ? prst_cnt_q : prst_cnt_q + PRST_W'(1);
        if (prst_cnt_d >= PRST_W'(PLL_RST_CYCLES)) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_HOLD: begin
        hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK_LOST;
        end else if (hold_cnt_d >= HOLD_W'(HOLD_CYCLES)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK_LOST;
        end else if (soft_rst_req) begin
          state_d = S_HOLD;
          cause_d = CAUSE_SOFT;
        end else if (wdt_exp_c) begin
          state_d = S_HOLD;
          cause_d = CAUSE_WDT;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
      end
    endcase

    // Every state change starts the destination state's counters from zero.
    if (state_d != state_q) begin
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      to_cnt_d   = '0;
      prst_cnt_d = '0;
    end

    pll_resetb_d = (state_d != S_PLL_RST);
    core_reset_d = (state_d != S_RUN);
    running_d    = (state_d == S_RUN);
  end

  always_ff @(posedge c) begin
    if (r) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      to_cnt_q     <= '0;
      prst_cnt_q   <= '0;
      cause_q      <= CAUSE_POR;
      pll_resetb_q <= 1'b1;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      lock_meta_q  <= pll_locked;
      lock_s_q     <= lock_meta_q;
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      to_cnt_q     <= to_cnt_d;
      prst_cnt_q   <= prst_cnt_d;
      cause_q      <= cause_d;
      pll_resetb_q <= pll_resetb_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench for clk_reset_sequencer; watchdog scenarios follow CLK_RESET_SEQUENCER_WDT_EN.
module tb_clk_reset_sequencer;

  localparam int unsigned TB_TIMEOUT = 300;
  localparam int unsigned TB_WDT     = 16;
  localparam int unsigned POR_LAT    = 134;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       wdt_kick = 1'b1;
  logic       pll_resetb;
  logic       core_reset;
  logic       running;
  logic [1:0] reset_cause;

  typedef struct {
    string       name;
    int unsigned v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned edge_n = 0;

  clk_reset_sequencer #(
    .LOCK_TIMEOUT (TB_TIMEOUT),
    .WDT_CYCLES   (TB_WDT)
  ) dut (
    .c            (c),
    .r            (r),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .wdt_kick     (wdt_kick),
    .pll_resetb   (pll_resetb),
    .core_reset   (core_reset),
    .running      (running),
    .reset_cause  (reset_cause)
  );

  always #5 c = ~c;
  always @(posedge c) edge_n <= edge_n + 1;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic expect_v(input string n, input int unsigned v);
    exp_t x;
    x.name = n;
    x.v    = v;
    sb.push_back(x);
  endtask

  function automatic int unsigned outs();
    return 32'({core_reset, pll_resetb, running, reset_cause});
  endfunction

  function automatic logic cur(input int sel);
    case (sel)
      0:       return core_reset;
      1:       return pll_resetb;
      default: return running;
    endcase
  endfunction

  // Returns the edge number at which the selected output first shows val, or 0 on timeout.
  task automatic wait_out(input int sel, input logic val, input int budget,
                          output int unsigned t);
    t = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cur(sel) === val) begin
        t = edge_n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    expect_v("reset_outputs", 32'b11000);
    r = 1'b1;
    repeat (3) tick();
    e = sb.pop_front(); total++;
    if (outs() !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, outs(), e.v); end
  endtask

  task automatic test_por();
    int unsigned t0, t;
    expect_v("por_latency", POR_LAT);
    expect_v("por_running", 1);
    expect_v("por_cause", 0);
    pll_locked = 1'b1;
    r = 1'b0;
    t0 = edge_n;
    wait_out(0, 1'b0, 400, t);
    e = sb.pop_front(); total++;
    if ((t - t0) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t - t0, e.v); end
    e = sb.pop_front(); total++;
    if (32'(running) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, running, e.v); end
    e = sb.pop_front(); total++;
    if (32'(reset_cause) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, reset_cause, e.v); end
  endtask

  task automatic test_lock_loss();
    int unsigned t0, t, t2;
    expect_v("lock_loss_delay", 3);
    expect_v("lock_loss_outputs", 32'b11001);
    expect_v("relock_latency", POR_LAT);
    pll_locked = 1'b0;
    t0 = edge_n;
    tick();
    pll_locked = 1'b1;
    wait_out(0, 1'b1, 10, t);
    e = sb.pop_front(); total++;
    if ((t - t0) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t - t0, e.v); end
    e = sb.pop_front(); total++;
    if (outs() !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, outs(), e.v); end
    wait_out(0, 1'b0, 400, t2);
    e = sb.pop_front(); total++;
    if ((t2 - (t0 + 1)) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t2 - (t0 + 1), e.v); end
  endtask

  task automatic test_soft();
    int unsigned t0, t, t2;
    expect_v("soft_delay", 1);
    expect_v("soft_cause", 2);
    expect_v("soft_hold", 128);
    expect_v("soft_vs_lock_outputs", 32'b11001);
    expect_v("soft_vs_lock_release", POR_LAT);
    soft_rst_req = 1'b1;
    t0 = edge_n;
    wait_out(0, 1'b1, 10, t);
    soft_rst_req = 1'b0;
    e = sb.pop_front(); total++;
    if ((t - t0) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t - t0, e.v); end
    e = sb.pop_front(); total++;
    if (32'(reset_cause) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, reset_cause, e.v); end
    wait_out(0, 1'b0, 300, t2);
    e = sb.pop_front(); total++;
    if ((t2 - t) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t2 - t, e.v); end
    // Soft request lands on the same cycle the synchronised lock drop reaches the FSM.
    pll_locked = 1'b0;
    t0 = edge_n;
    tick();
    pll_locked = 1'b1;
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    e = sb.pop_front(); total++;
    if (outs() !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, outs(), e.v); end
    wait_out(0, 1'b0, 400, t2);
    e = sb.pop_front(); total++;
    if ((t2 - (t0 + 1)) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t2 - (t0 + 1), e.v); end
  endtask

`ifdef CLK_RESET_SEQUENCER_WDT_EN
  task automatic test_wdt();
    int unsigned t0, t, t2, n;
    expect_v("wdt_expiry", TB_WDT);
    expect_v("wdt_cause", 3);
    expect_v("wdt_release", 128);
    expect_v("wdt_kicked_resets", 0);
    wdt_kick = 1'b0;
    t0 = edge_n;
    wait_out(0, 1'b1, 60, t);
    wdt_kick = 1'b1;
    e = sb.pop_front(); total++;
    if ((t - t0) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t - t0, e.v); end
    e = sb.pop_front(); total++;
    if (32'(reset_cause) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, reset_cause, e.v); end
    wait_out(0, 1'b0, 300, t2);
    e = sb.pop_front(); total++;
    if ((t2 - t) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t2 - t, e.v); end
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      wdt_kick = ((i % 10) == 9);
      tick();
      if (core_reset !== 1'b0) n++;
    end
    wdt_kick = 1'b1;
    e = sb.pop_front(); total++;
    if (n !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.v); end
  endtask
`else
  task automatic test_wdt();
    int unsigned n;
    expect_v("idle_resets", 0);
    expect_v("idle_cause", 1);
    n = 0;
    wdt_kick = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (core_reset !== 1'b0) n++;
    end
    wdt_kick = 1'b1;
    e = sb.pop_front(); total++;
    if (n !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.v); end
    e = sb.pop_front(); total++;
    if (32'(reset_cause) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, reset_cause, e.v); end
  endtask
`endif

  task automatic test_timeout_and_midreset();
    int unsigned t_rise, t_low, t_high, t_low2, fell, ph, t0, t;
    expect_v("timeout_delay", TB_TIMEOUT);
    expect_v("timeout_core_released", 0);
    expect_v("pll_reset_width", 8);
    expect_v("timeout_second", TB_TIMEOUT);
    expect_v("midpulse_pll_resetb", 0);
    expect_v("midreset_outputs", 32'b11000);
    expect_v("midreset_latency", POR_LAT);
    t_rise = 0; t_low = 0; t_high = 0; t_low2 = 0; fell = 0; ph = 3;
    // Lock pattern 1,1,1,0 never gives four consecutive lock cycles.
    for (int i = 0; i < 2000 && t_low2 == 0; i++) begin
      pll_locked = ((ph % 4) != 3);
      ph++;
      tick();
      if (t_rise == 0 && core_reset === 1'b1) t_rise = edge_n;
      else if (t_rise != 0 && core_reset !== 1'b1) fell++;
      if (t_low == 0 && pll_resetb === 1'b0) t_low = edge_n;
      else if (t_low != 0 && t_high == 0 && pll_resetb === 1'b1) t_high = edge_n;
      else if (t_high != 0 && pll_resetb === 1'b0) t_low2 = edge_n;
    end
    e = sb.pop_front(); total++;
    if ((t_low - t_rise) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t_low - t_rise, e.v); end
    e = sb.pop_front(); total++;
    if (fell !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, fell, e.v); end
    e = sb.pop_front(); total++;
    if ((t_high - t_low) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t_high - t_low, e.v); end
    e = sb.pop_front(); total++;
    if ((t_low2 - t_high) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t_low2 - t_high, e.v); end
    tick();
    tick();
    e = sb.pop_front(); total++;
    if (32'(pll_resetb) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, pll_resetb, e.v); end
    r = 1'b1;
    tick();
    e = sb.pop_front(); total++;
    if (outs() !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, outs(), e.v); end
    pll_locked = 1'b1;
    r = 1'b0;
    t0 = edge_n;
    wait_out(0, 1'b0, 400, t);
    e = sb.pop_front(); total++;
    if ((t - t0) !== e.v) begin bad++; $display("FAIL %s: got %0d expected %0d", e.name, t - t0, e.v); end
  endtask

  initial begin
    test_reset();
    test_por();
    test_lock_loss();
    test_soft();
    test_wdt();
    test_timeout_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
